// File: rtl/diff_fifo_pkg.sv
// rtl/diff_fifo_pkg.sv - shared widths and frame type for the difftest C2H path
package diff_fifo_pkg;

    localparam int unsigned DIFF_FRAME_WIDTH = 4064;
    localparam int unsigned DIFF_STAT_WIDTH  = 32;

    typedef logic [DIFF_FRAME_WIDTH-1:0] diff_frame_t;

endpackage : diff_fifo_pkg

// File: rtl/diff_fifo_stat.sv
// rtl/diff_fifo_stat.sv - input stall counter and level high-water mark
module diff_fifo_stat
    import diff_fifo_pkg::*;
#(
    parameter int unsigned LEVEL_WIDTH = 3
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       in_valid_i,
    input  logic                       in_ready_i,
    input  logic [LEVEL_WIDTH-1:0]     count_i,
    output logic [DIFF_STAT_WIDTH-1:0] stall_cnt_o,
    output logic [LEVEL_WIDTH-1:0]     max_level_o
);

    logic [DIFF_STAT_WIDTH-1:0] stall_q, stall_d;
    logic [LEVEL_WIDTH-1:0]     max_q, max_d;

    always_comb begin
        stall_d = stall_q;
        max_d   = max_q;
        // Saturate rather than wrap so a long stall never reads as a short one.
        if (in_valid_i && !in_ready_i && (stall_q != {DIFF_STAT_WIDTH{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
        if (count_i > max_q) begin
            max_d = count_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_q <= '0;
            max_q   <= '0;
        end else begin
            stall_q <= stall_d;
            max_q   <= max_d;
        end
    end

    assign stall_cnt_o = stall_q;
    assign max_level_o = max_q;

endmodule : diff_fifo_stat

// File: rtl/diff_frame_fifo.sv
// rtl/diff_frame_fifo.sv - difftest frame buffer ahead of the C2H packer; stats under DIFF_FIFO_STAT_EN
module diff_frame_fifo
    import diff_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DIFF_FRAME_WIDTH,
    parameter int unsigned ADDR_WIDTH = 2
) (
    input  logic                       m_axis_c2h_aclk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       data_valid,
    input  logic                       data_next,
    output logic [DATA_WIDTH-1:0]      data,
    output logic [ADDR_WIDTH:0]        level,
    output logic [DIFF_STAT_WIDTH-1:0] stall_cnt,
    output logic [ADDR_WIDTH:0]        max_level
);

    localparam int unsigned        DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  push;
    logic                  pop;

    // A pop in the same cycle never frees room for a push; the slot opens next cycle.
    assign in_ready   = !rst && (count_q != DEPTH_CNT);
    assign push       = in_valid && in_ready;
    // Gated by data_next so the packer sees a frame only when it is ready to take exactly one.
    assign data_valid = (count_q != '0) && data_next;
    assign pop        = data_valid;
    assign data       = mem_q[rd_ptr_q];
    assign level      = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge m_axis_c2h_aclk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Frame storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge m_axis_c2h_aclk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

`ifdef DIFF_FIFO_STAT_EN
    diff_fifo_stat #(
        .LEVEL_WIDTH (ADDR_WIDTH + 1)
    ) u_stat (
        .clk_i       (m_axis_c2h_aclk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_i  (in_ready),
        .count_i     (count_q),
        .stall_cnt_o (stall_cnt),
        .max_level_o (max_level)
    );
`else
    assign stall_cnt = '0;
    assign max_level = '0;
`endif

endmodule : diff_frame_fifo

// File: tb/tb_diff_frame_fifo.sv
// tb/tb_diff_frame_fifo.sv - table-driven bench for diff_frame_fifo
module tb_diff_frame_fifo;

    localparam int DW = 4064;
    localparam int AW = 2;
`ifdef DIFF_FIFO_STAT_EN
    localparam bit STAT_EN = 1'b1;
`else
    localparam bit STAT_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          data_valid;
    logic          data_next;
    logic [DW-1:0] data;
    logic [AW:0]   level;
    logic [31:0]   stall_cnt;
    logic [AW:0]   max_level;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    diff_frame_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .m_axis_c2h_aclk (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data         (in_data),
        .data_valid      (data_valid),
        .data_next       (data_next),
        .data            (data),
        .level           (level),
        .stall_cnt       (stall_cnt),
        .max_level       (max_level)
    );

    typedef struct {
        logic        rst;
        logic        vld;
        logic [7:0]  pat;
        logic        nxt;
        logic        rdy;
        logic        dv;
        logic [2:0]  lvl;
        logic [7:0]  dpat;
        logic [31:0] stall;
        logic [2:0]  mx;
    } vec_t;

    vec_t tbl [18];

    function automatic logic [DW-1:0] rep(input logic [7:0] b);
        return {(DW/8){b}};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_data(input string name, input logic [7:0] exp);
        n_vec++;
        if (data !== rep(exp)) begin
            n_bad++;
            $display("FAIL %s: got low byte %0h expected pattern %0h", name, data[7:0], exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] mq [$];
    int         mcount;
    int         pushed;
    int         popped;

    initial begin
        //          rst  vld  pat    nxt  rdy  dv   lvl  dpat   stall mx
        tbl[0]  = '{1'b1,1'b0,8'h00,1'b0,1'b0,1'b0,3'd0,8'h00,32'd0,3'd0};
        tbl[1]  = '{1'b1,1'b1,8'hEE,1'b1,1'b0,1'b0,3'd0,8'h00,32'd0,3'd0};
        tbl[2]  = '{1'b0,1'b1,8'h5A,1'b1,1'b1,1'b0,3'd0,8'h00,32'd0,3'd0};
        tbl[3]  = '{1'b0,1'b0,8'h00,1'b1,1'b1,1'b1,3'd1,8'h5A,32'd0,3'd0};
        tbl[4]  = '{1'b0,1'b0,8'h00,1'b1,1'b1,1'b0,3'd0,8'h00,32'd0,3'd1};
        tbl[5]  = '{1'b0,1'b1,8'h01,1'b0,1'b1,1'b0,3'd0,8'h00,32'd0,3'd1};
        tbl[6]  = '{1'b0,1'b1,8'h02,1'b0,1'b1,1'b0,3'd1,8'h00,32'd0,3'd1};
        tbl[7]  = '{1'b0,1'b1,8'h03,1'b0,1'b1,1'b0,3'd2,8'h00,32'd0,3'd1};
        tbl[8]  = '{1'b0,1'b1,8'h04,1'b0,1'b1,1'b0,3'd3,8'h00,32'd0,3'd2};
        tbl[9]  = '{1'b0,1'b1,8'h05,1'b0,1'b0,1'b0,3'd4,8'h00,32'd0,3'd3};
        tbl[10] = '{1'b0,1'b1,8'h05,1'b0,1'b0,1'b0,3'd4,8'h00,32'd1,3'd4};
        tbl[11] = '{1'b0,1'b1,8'h05,1'b1,1'b0,1'b1,3'd4,8'h01,32'd2,3'd4};
        tbl[12] = '{1'b0,1'b1,8'h05,1'b0,1'b1,1'b0,3'd3,8'h00,32'd3,3'd4};
        tbl[13] = '{1'b0,1'b0,8'h00,1'b1,1'b0,1'b1,3'd4,8'h02,32'd3,3'd4};
        tbl[14] = '{1'b0,1'b0,8'h00,1'b1,1'b1,1'b1,3'd3,8'h03,32'd3,3'd4};
        tbl[15] = '{1'b0,1'b0,8'h00,1'b1,1'b1,1'b1,3'd2,8'h04,32'd3,3'd4};
        tbl[16] = '{1'b0,1'b0,8'h00,1'b1,1'b1,1'b1,3'd1,8'h05,32'd3,3'd4};
        tbl[17] = '{1'b0,1'b0,8'h00,1'b1,1'b1,1'b0,3'd0,8'h00,32'd3,3'd4};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; data_next = 1'b0;
        #1;

        for (int i = 0; i < 18; i++) begin
            rst       = tbl[i].rst;
            in_valid  = tbl[i].vld;
            in_data   = rep(tbl[i].pat);
            data_next = tbl[i].nxt;
            @(negedge clk);
            chk($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
            chk($sformatf("v%0d data_valid", i), 32'(data_valid), 32'(tbl[i].dv));
            chk($sformatf("v%0d level", i), 32'(level), 32'(tbl[i].lvl));
            if (tbl[i].dv) chk_data($sformatf("v%0d data", i), tbl[i].dpat);
            chk($sformatf("v%0d stall_cnt", i), stall_cnt, STAT_EN ? tbl[i].stall : 32'd0);
            chk($sformatf("v%0d max_level", i), 32'(max_level), STAT_EN ? 32'(tbl[i].mx) : 32'd0);
            tick();
        end

        // Packer emulation: data_next high 1 cycle, low 10; six frames across pointer wrap.
        mq.delete(); mcount = 0; pushed = 0; popped = 0;
        for (int c = 0; c < 200 && popped < 6; c++) begin
            data_next = ((c % 11) == 0);
            in_valid  = (pushed < 6);
            in_data   = rep(8'hA0 + 8'(pushed));
            @(negedge clk);
            chk($sformatf("wrap c%0d in_ready", c), 32'(in_ready), 32'(mcount != 4));
            chk($sformatf("wrap c%0d data_valid", c), 32'(data_valid), 32'((mcount != 0) && data_next));
            if (data_valid && mq.size() > 0) begin
                chk_data($sformatf("wrap pop%0d data", popped), mq[0]);
            end
            if (data_valid) begin
                void'(mq.pop_front());
                popped++;
                mcount--;
            end
            if (in_valid && (mcount + (data_valid ? 1 : 0)) != 4) begin
                mq.push_back(8'hA0 + 8'(pushed));
                pushed++;
                mcount++;
            end
            tick();
        end
        chk("wrap frames popped", 32'(popped), 32'd6);
        data_next = 1'b0;
        in_valid  = 1'b0;

        // Reset mid-stream with three frames stored.
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = rep(8'hC1 + 8'(k));
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("pre-reset level", 32'(level), 32'd3);
        data_next = 1'b1;
        rst = 1'b1;
        #1;
        chk("reset data_valid", 32'(data_valid), 32'd0);
        chk("reset level", 32'(level), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd0);
        chk("reset stall_cnt", stall_cnt, 32'd0);
        tick();
        rst = 1'b0;
        data_next = 1'b0;
        in_valid = 1'b1;
        in_data = rep(8'hB7);
        @(negedge clk);
        chk("post-reset in_ready", 32'(in_ready), 32'd1);
        chk("post-reset data_valid", 32'(data_valid), 32'd0);
        tick();
        in_valid = 1'b0;
        data_next = 1'b1;
        @(negedge clk);
        chk("B data_valid", 32'(data_valid), 32'd1);
        chk("B level", 32'(level), 32'd1);
        chk_data("B data", 8'hB7);
        tick();
        @(negedge clk);
        chk("B drained level", 32'(level), 32'd0);
        chk("B no duplicate", 32'(data_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_diff_frame_fifo

// File: doc/diff_frame_fifo.md
# diff_frame_fifo

Wide frame buffer feeding the C2H AXI-Stream packer in the FPGA difftest path. Accepts one DATA_WIDTH-bit difftest frame per cycle from the core-side collector. Stores up to DEPTH frames and presents them one at a time on the packer's `data_valid`/`data_next` interface, absorbing the packer's multi-beat serialisation time. Runs entirely in the XDMA C2H clock domain.

## Interface
- `DATA_WIDTH`, 4064: frame width in bits; must equal the packer's DATA_WIDTH.
- `ADDR_WIDTH`, 2: pointer width; DEPTH = 2**ADDR_WIDTH frames (ADDR_WIDTH ≥ 1).
- `m_axis_c2h_aclk`  in  1: sole clock; all state is on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: core-side frame present.
- `in_ready`  out  1: frame accepted on a cycle where `in_valid && in_ready`.
- `in_data`  in  DATA_WIDTH: core-side frame.
- `data_valid`  out  1: head frame offered to the packer.
- `data_next`  in  1: packer idle and able to sample; driven from a register in the packer.
- `data`  out  DATA_WIDTH: head frame; valid whenever `data_valid`.
- `level`  out  ADDR_WIDTH+1: frames currently stored, 0..DEPTH.
- `stall_cnt`  out  32: cycles with `in_valid && !in_ready` (statistics; see Configuration).
- `max_level`  out  ADDR_WIDTH+1: high-water mark of `level` (statistics).

## Operation
- Storage is a DEPTH-entry register array with `wr_ptr` and `rd_ptr` (ADDR_WIDTH bits, natural wrap-around) and `count` (ADDR_WIDTH+1 bits).
- `push = in_valid && in_ready`, where `in_ready = !rst && (count != DEPTH)`. A push writes `mem[wr_ptr]` and increments `wr_ptr`.
- `data_valid = (count != 0) && data_next`. This is combinational from registers only, so there is no loop.
  - The packer samples on any cycle with `data_valid` high. Gating with `data_next` guarantees a frame is never offered during the packer's busy states or its first idle cycle.
  - This prevents double sampling.
- `pop = data_valid`. A pop increments `rd_ptr`. `data = mem[rd_ptr]` is a combinational read of the head.
- `count` update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full: `in_ready` is low. A same-cycle pop does not enable a push; the freed slot is usable next cycle.
- Empty: no bypass. A frame pushed at edge N is first offered in the cycle after edge N.
- `data` holds `mem[rd_ptr]` even when `data_valid` is low. Its contents while empty are don't-care.
- Storage is not reset. Only pointers, `count` and statistics are reset.

## Timing
- Reset values (asserted asynchronously):
  - `wr_ptr`, `rd_ptr` and `count` are 0.
  - `in_ready` = 0 while `rst` is high and 1 on the first cycle after release.
  - `data_valid` = 0, `level` = 0, `stall_cnt` = 0, `max_level` = 0.
- Reset mid-operation: all stored frames are discarded immediately, with no partial output. The packer is reset by its own `rstn`.
- Latency from input accept to `data_valid`: 1 cycle minimum, provided `data_next` is high.
- Throughput is bounded by the packer: one frame per (AXIS beats + 3) cycles. `in_ready` falls only when DEPTH frames are pending.
- `level` equals the registered `count`.

## Configuration
- `DIFF_FIFO_STAT_EN` defined:
  - `stall_cnt` increments on every cycle with `in_valid && !in_ready` and saturates at 32'hFFFF_FFFF.
  - `max_level` is updated to `count` whenever `count > max_level`.
  - Both clear only on `rst`.
- `DIFF_FIFO_STAT_EN` undefined: `stall_cnt` and `max_level` are tied to 0 and no counter flops are synthesised. Ports remain present.

## Structure
- Shared package `diff_fifo_pkg`:
  - `DIFF_FRAME_WIDTH` = 4064.
  - `DIFF_STAT_WIDTH` = 32.
  - Typedef `diff_frame_t` (logic [DIFF_FRAME_WIDTH-1:0]), reused by the collector and the packer wrapper.
- One sub-module `diff_fifo_stat`: the stall counter and watermark, instantiated only under `DIFF_FIFO_STAT_EN`.
- Storage, pointers and handshake logic stay in the top module.

## Test plan
Benches use ADDR_WIDTH=2 and DATA_WIDTH=4064.

- Reset then push frame A=all-0x5A with `data_next` high:
  - `data_valid` is high the cycle after the push with `data` = A.
  - `level` goes 1→0 after the pop.
- Hold `data_next` low and push 5 frames back to back:
  - `in_ready` drops after the 4th push.
  - `level` = 4, and the 5th frame is held at the input.
  - With `DIFF_FIFO_STAT_EN` defined, `stall_cnt` increments every held cycle and `max_level` = 4.
- Full FIFO, then raise `data_next` for one cycle:
  - Exactly one pop occurs, and `in_ready` returns to 1 on the next cycle, not the same one.
- Push 6 frames with `data_next` toggled to emulate the packer: high 1 cycle, low 10, repeat.
  - Output order equals input order across pointer wrap.
  - No frame is offered while `data_next` is low, and no frame is duplicated.
- Assert `rst` mid-stream with 3 frames stored:
  - `data_valid` and `level` go to 0 immediately, and `in_ready` is 0 while `rst` is high.
  - After release, a new push B appears first with B intact.
- Build without `DIFF_FIFO_STAT_EN` and repeat the 5-push scenario: `stall_cnt` = 0 and `max_level` = 0.
